spi_master_multi: RTL and testbench

Parametrised SPI master with configurable frame width, slave count, all four CPOL/CPHA modes and a programmable SCLK divider. Full-duplex: shifts tx_data out on mosi while capturing miso into rx_data. It is driven by a start/busy/done handshake from the system controller and fans out one active-low chip select per slave. It supersedes the fixed 16-bit, two-slave, mode-0-only master.

---
 rtl/spi_pkg.sv | 23 ++
 rtl/spi_clk_gen.sv | 30 +++
 rtl/spi_master_multi.sv | 143 ++++++++++++++
 tb/tb_spi_master_multi.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the multi-slave SPI master.
// Mode constants name the CPOL/CPHA encodings; sel_width derives the slave index width.
package spi_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_XFER,
      ST_HOLD,
      ST_GAP
   } spi_state_e;

   localparam logic CPOL_LOW   = 1'b0;
   localparam logic CPOL_HIGH  = 1'b1;
   localparam logic CPHA_LEAD  = 1'b0;
   localparam logic CPHA_TRAIL = 1'b1;

   // A single slave still needs a one-bit select port.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer for the SPI master: ticks every div+1 cycles while run is high
// and tracks whether the next tick is a leading or trailing SCLK edge during XFER.
module spi_clk_gen #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   input  logic             xfer,
   input  logic [DIV_W-1:0] div,
   output logic             tick,
   output logic             leading
);

   logic [DIV_W-1:0] cnt;
   logic             trail_q;

   assign tick    = run && (cnt == div);
   assign leading = !trail_q;

   // States only change on a tick, so wrapping here also restarts the count on every state entry.
   always_ff @(posedge clk) begin
      if (reset || !run || tick) cnt <= '0;
      else                       cnt <= cnt + 1'b1;

      if (reset || !xfer) trail_q <= 1'b0;
      else if (tick)      trail_q <= !trail_q;
   end

endmodule

// File: rtl/spi_master_multi.sv
// Full-duplex SPI master: configurable width, slave count, CPOL/CPHA and SCLK divider.
// Handshake: start is taken only in IDLE; busy covers the frame; done pulses in its last cycle.
module spi_master_multi
   import spi_pkg::*;
#(
   parameter  int DATA_W   = 16,
   parameter  int N_SLAVES = 2,
   parameter  int DIV_W    = 8,
   localparam int SEL_W    = sel_width(N_SLAVES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [SEL_W-1:0]  slave_sel,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [DIV_W-1:0]  clk_div,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              miso,
   output logic              sclk,
   output logic              mosi,
   output logic [N_SLAVES-1:0] cs_n,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_data,
   output logic              sel_err,
   output spi_state_e        fsm_state
);

   localparam int             EW        = $clog2(2 * DATA_W);
   localparam logic [EW-1:0]  LAST_EDGE = EW'(2 * DATA_W - 1);

   spi_state_e        state, state_nx;
   logic [DATA_W-1:0] tx_shift, rx_shift, rx_q;
   logic [SEL_W-1:0]  sel_q;
   logic              cpol_q, cpha_q;
   logic [DIV_W-1:0]  div_q;
   logic [EW-1:0]     edge_cnt;
   logic              sclk_q, mosi_q, sel_err_q;

   logic tick, leading;
   logic sel_ok, accept, xfer_tick, last_edge, sample, drive, done_c;

   spi_clk_gen #(.DIV_W(DIV_W)) u_clk_gen (
      .clk     (clk),
      .reset   (reset),
      .run     (state != ST_IDLE),
      .xfer    (state == ST_XFER),
      .div     (div_q),
      .tick    (tick),
      .leading (leading)
   );

   assign sel_ok    = 32'(slave_sel) < N_SLAVES;
   assign accept    = (state == ST_IDLE) && start && sel_ok;
   assign xfer_tick = (state == ST_XFER) && tick;
   assign last_edge = (edge_cnt == LAST_EDGE);
   // CPHA=0 samples on leading edges, CPHA=1 on trailing; the other edge drives mosi.
   assign sample    = xfer_tick && (leading != cpha_q);
   assign drive     = xfer_tick && (leading == cpha_q) && !((cpha_q == CPHA_LEAD) && last_edge);

   always_comb begin
      state_nx = state;
      done_c   = 1'b0;
      busy     = 1'b0;
      cs_n     = '1;
      unique case (state)
         ST_IDLE:  if (accept) state_nx = ST_SETUP;
         ST_SETUP: if (tick) state_nx = ST_XFER;
         ST_XFER:  if (tick && last_edge) state_nx = ST_HOLD;
         ST_HOLD:  if (tick) state_nx = ST_GAP;
         ST_GAP: begin
            if (tick) begin
               state_nx = ST_IDLE;
               done_c   = 1'b1;
            end
         end
         default:  state_nx = ST_IDLE;
      endcase
      busy = (state != ST_IDLE) && !done_c;
      if (state == ST_SETUP || state == ST_XFER || state == ST_HOLD) begin
         for (int i = 0; i < N_SLAVES; i++) begin
            if (32'(sel_q) == i) cs_n[i] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         tx_shift  <= '0;
         rx_shift  <= '0;
         rx_q      <= '0;
         sel_q     <= '0;
         cpol_q    <= CPOL_LOW;
         cpha_q    <= CPHA_LEAD;
         div_q     <= '0;
         edge_cnt  <= '0;
         sclk_q    <= CPOL_LOW;
         mosi_q    <= 1'b0;
         sel_err_q <= 1'b0;
      end else begin
         state     <= state_nx;
         sel_err_q <= (state == ST_IDLE) && start && !sel_ok;
         if (accept) begin
            sel_q    <= slave_sel;
            cpol_q   <= cpol;
            cpha_q   <= cpha;
            div_q    <= clk_div;
            rx_shift <= '0;
            edge_cnt <= '0;
            sclk_q   <= cpol;
            // CPHA=0 must present the MSB before the first (sampling) edge.
            if (cpha == CPHA_LEAD) begin
               mosi_q   <= tx_data[DATA_W-1];
               tx_shift <= tx_data << 1;
            end else begin
               mosi_q   <= 1'b0;
               tx_shift <= tx_data;
            end
         end
         if (xfer_tick) begin
            edge_cnt <= edge_cnt + 1'b1;
            sclk_q   <= !sclk_q;
         end
         if (sample) rx_shift <= {rx_shift[DATA_W-2:0], miso};
         if (drive) begin
            mosi_q   <= tx_shift[DATA_W-1];
            tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
         end
         if ((state == ST_HOLD) && tick) mosi_q <= 1'b0;
         if (done_c) rx_q <= rx_shift;
      end
   end

   assign sclk      = sclk_q;
   assign mosi      = mosi_q;
   assign done      = done_c;
   assign rx_data   = rx_q;
   assign sel_err   = sel_err_q;
   assign fsm_state = state;

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: table of mode/divider/slave vectors against a
// negedge slave model, plus hand sequences for select error, mid-frame reset and back-to-back starts.
module tb_spi_master_multi;
   import spi_pkg::*;

   localparam int DATA_W   = 16;
   localparam int N_SLAVES = 3;
   localparam int DIV_W    = 8;
   localparam int LIMIT    = 600;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic [1:0]        slave_sel = '0;
   logic              cpol = 1'b0;
   logic              cpha = 1'b0;
   logic [DIV_W-1:0]  clk_div = '0;
   logic [DATA_W-1:0] tx_data = '0;
   logic              miso;
   logic              sclk, mosi, busy, done, sel_err;
   logic [N_SLAVES-1:0] cs_n;
   logic [DATA_W-1:0] rx_data;
   spi_state_e        fsm_state;

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;

   // Slave model state
   logic              loopback = 1'b0;
   logic              m_cpol = 1'b0;
   logic              m_cpha = 1'b0;
   logic [DATA_W-1:0] s_pat = '0;
   logic [DATA_W-1:0] s_shift = '0;
   logic [DATA_W-1:0] s_rx = '0;
   int                s_cnt = 0;
   logic              miso_s = 1'b0;
   logic              prev_sclk = 1'b0;
   logic              prev_cs = 1'b0;

   assign miso = loopback ? mosi : miso_s;

   always #5 clk = ~clk;

   spi_master_multi #(.DATA_W(DATA_W), .N_SLAVES(N_SLAVES), .DIV_W(DIV_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .slave_sel (slave_sel),
      .cpol      (cpol),
      .cpha      (cpha),
      .clk_div   (clk_div),
      .tx_data   (tx_data),
      .miso      (miso),
      .sclk      (sclk),
      .mosi      (mosi),
      .cs_n      (cs_n),
      .busy      (busy),
      .done      (done),
      .rx_data   (rx_data),
      .sel_err   (sel_err),
      .fsm_state (fsm_state)
   );

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt++;
   end

   // Slave: shifts pattern out on the non-sampling edge, captures mosi on the sampling edge.
   always @(negedge clk) begin
      logic cs_act, lead;
      cs_act = (cs_n != '1);
      if (cs_act && !prev_cs) begin
         s_shift = s_pat;
         s_rx    = '0;
         s_cnt   = 0;
         if (!m_cpha) begin
            miso_s  = s_shift[DATA_W-1];
            s_shift = s_shift << 1;
         end
      end else if (cs_act && (sclk != prev_sclk)) begin
         lead = (sclk != m_cpol);
         if (lead ^ m_cpha) begin
            s_rx = {s_rx[DATA_W-2:0], mosi};
            s_cnt++;
         end else begin
            miso_s  = s_shift[DATA_W-1];
            s_shift = s_shift << 1;
         end
      end
      prev_sclk = sclk;
      prev_cs   = cs_act;
   end

   typedef struct {
      logic              cpol;
      logic              cpha;
      logic [DIV_W-1:0]  div;
      logic [1:0]        sel;
      logic [DATA_W-1:0] tx;
      logic [DATA_W-1:0] pat;
      logic              loop;
      logic [DATA_W-1:0] exp_rx;
      int                exp_cyc;
      logic [N_SLAVES-1:0] exp_cs;
   } vec_t;

   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int k;
      @(negedge clk);
      m_cpol = v.cpol; m_cpha = v.cpha; s_pat = v.pat; loopback = v.loop;
      cpol = v.cpol; cpha = v.cpha; clk_div = v.div; slave_sel = v.sel; tx_data = v.tx;
      start = 1'b1;
      @(negedge clk);
      k = 1;
      check("busy_first", 32'(busy), 32'd1);
      check("cs_n_active", 32'(cs_n), 32'(v.exp_cs));
      check("sclk_setup", 32'(sclk), 32'(v.cpol));
      // Inputs disturbed mid-frame must not affect it; start pulse here must be ignored.
      tx_data = ~v.tx; cpol = ~v.cpol; clk_div = 8'd0; slave_sel = 2'd0;
      while (done !== 1'b1 && k < LIMIT) begin
         @(negedge clk);
         k++;
         if (k == 2) start = 1'b0;
      end
      check("done_cycle", 32'(k), 32'(v.exp_cyc));
      check("busy_at_done", 32'(busy), 32'd0);
      @(negedge clk);
      cpol = v.cpol;
      check("rx_data", 32'(rx_data), 32'(v.exp_rx));
      check("done_one_cycle", 32'(done), 32'd0);
      check("sclk_idle", 32'(sclk), 32'(v.cpol));
      check("cs_n_idle", 32'(cs_n), 32'h7);
      check("slave_samples", 32'(s_cnt), 32'(DATA_W));
      check("slave_rx", 32'(s_rx), 32'(v.tx));
   endtask

   initial begin
      int k, dc;
      logic [DATA_W-1:0] rx_before;

      vecs[0] = '{1'b0, 1'b0, 8'd0, 2'd0, 16'hA5C3, 16'h0000, 1'b1, 16'hA5C3,  35, 3'b110};
      vecs[1] = '{1'b1, 1'b1, 8'd3, 2'd1, 16'h1234, 16'hBEEF, 1'b0, 16'hBEEF, 140, 3'b101};
      vecs[2] = '{1'b0, 1'b1, 8'd1, 2'd2, 16'h5A0F, 16'hC0DE, 1'b0, 16'hC0DE,  70, 3'b011};
      vecs[3] = '{1'b1, 1'b0, 8'd1, 2'd0, 16'h8001, 16'h7FFE, 1'b0, 16'h7FFE,  70, 3'b110};
      vecs[4] = '{1'b0, 1'b0, 8'd2, 2'd1, 16'hFFFF, 16'h0001, 1'b0, 16'h0001, 105, 3'b101};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_sclk", 32'(sclk), 32'd0);
      check("rst_mosi", 32'(mosi), 32'd0);
      check("rst_cs_n", 32'(cs_n), 32'h7);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sel_err", 32'(sel_err), 32'd0);
      check("rst_rx_data", 32'(rx_data), 32'd0);
      check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
      reset = 1'b0;

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // Out-of-range select
      @(negedge clk);
      slave_sel = 2'd3; tx_data = 16'h1111; start = 1'b1;
      rx_before = rx_data; dc = done_cnt;
      @(negedge clk);
      check("sel_err_pulse", 32'(sel_err), 32'd1);
      check("sel_err_busy", 32'(busy), 32'd0);
      check("sel_err_cs_n", 32'(cs_n), 32'h7);
      start = 1'b0; slave_sel = 2'd0;
      @(negedge clk);
      check("sel_err_clear", 32'(sel_err), 32'd0);
      repeat (40) @(negedge clk);
      check("sel_err_no_done", 32'(done_cnt), 32'(dc));
      check("sel_err_rx_kept", 32'(rx_data), 32'(rx_before));

      // Reset at XFER edge 10 (CPOL=1 so the sclk reset value is visible)
      @(negedge clk);
      m_cpol = 1'b1; m_cpha = 1'b0; loopback = 1'b1;
      cpol = 1'b1; cpha = 1'b0; clk_div = 8'd0; slave_sel = 2'd1; tx_data = 16'hF0F0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dc = done_cnt;
      repeat (10) @(negedge clk);
      check("pre_reset_xfer", 32'(fsm_state), 32'(ST_XFER));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_rst_cs_n", 32'(cs_n), 32'h7);
      check("mid_rst_sclk", 32'(sclk), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_mosi", 32'(mosi), 32'd0);
      check("mid_rst_rx", 32'(rx_data), 32'd0);
      repeat (60) @(negedge clk);
      check("mid_rst_no_done", 32'(done_cnt), 32'(dc));
      run_vec(vecs[0]);

      // Back-to-back with start held high
      @(negedge clk);
      m_cpol = 1'b0; m_cpha = 1'b0; loopback = 1'b1;
      cpol = 1'b0; cpha = 1'b0; clk_div = 8'd0; slave_sel = 2'd0; tx_data = 16'h3C3C;
      start = 1'b1;
      @(negedge clk);
      k = 1;
      while (done !== 1'b1 && k < LIMIT) begin
         @(negedge clk);
         k++;
      end
      check("b2b_done1", 32'(k), 32'd35);
      @(negedge clk);
      check("b2b_idle_gap", 32'(busy), 32'd0);
      check("b2b_rx1", 32'(rx_data), 32'h3C3C);
      tx_data = 16'hC3C3;
      @(negedge clk);
      check("b2b_restart", 32'(busy), 32'd1);
      start = 1'b0;
      k = 1;
      while (done !== 1'b1 && k < LIMIT) begin
         @(negedge clk);
         k++;
      end
      check("b2b_done2", 32'(k), 32'd35);
      @(negedge clk);
      check("b2b_rx2", 32'(rx_data), 32'hC3C3);
      repeat (5) @(negedge clk);
      check("b2b_stays_idle", 32'(fsm_state), 32'(ST_IDLE));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
